// File: rtl/vga_pkg.sv
// Shared VGA definitions: default widths, sync polarity helper and colour constants.
package vga_pkg;

  localparam int NUM_LAYERS_DEF = 8;
  localparam int COLOR_W_DEF    = 12;
  localparam int SYNC_POL_DEF   = 0;
  localparam int IDX_W          = $clog2(NUM_LAYERS_DEF + 1);

  localparam logic [COLOR_W_DEF-1:0] BLACK = 12'h000;
  localparam logic [COLOR_W_DEF-1:0] WHITE = 12'hFFF;

  // Level a sync line sits at when it is not asserted.
  function automatic logic inactive_sync(input logic pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/vga_priority_select.sv
// Fixed-priority layer selector: lowest visible index wins, otherwise background.
module vga_priority_select #(
  parameter int NUM_LAYERS = 8,
  parameter int COLOR_W    = 12,
  parameter int IDX_W      = $clog2(NUM_LAYERS + 1)
) (
  input  logic [NUM_LAYERS-1:0]         visible,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [COLOR_W-1:0]            bg_rgb,
  output logic [COLOR_W-1:0]            sel_rgb,
  output logic [IDX_W-1:0]              sel_idx
);

  // Walk from lowest to highest priority so the lowest visible index is the last to overwrite.
  always_comb begin
    sel_rgb = bg_rgb;
    sel_idx = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      sel_rgb = visible[i] ? layer_rgb[i*COLOR_W +: COLOR_W] : sel_rgb;
      sel_idx = visible[i] ? IDX_W'(i) : sel_idx;
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage N-layer compositor with frame-shadowed configuration and matched sync delay.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int COLOR_W     = COLOR_W_DEF,
  parameter int SYNC_POL    = SYNC_POL_DEF,
  parameter int BLINK_SHIFT = 4,
  parameter int FRAME_W     = 8,
  parameter int KEY_EN      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            pixel_tick,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            video_on_in,
  input  logic [NUM_LAYERS*COLOR_W-1:0]   layer_rgb,
  input  logic [NUM_LAYERS-1:0]           layer_valid,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic [NUM_LAYERS-1:0]           blink_mask,
  input  logic [COLOR_W-1:0]              bg_rgb,
  input  logic [COLOR_W-1:0]              key_rgb,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic                            video_on_out,
  output logic [COLOR_W-1:0]              rgb_out,
  output logic [$clog2(NUM_LAYERS+1)-1:0] hit_layer,
  output logic [FRAME_W-1:0]              frame_cnt
);

  localparam int   HIT_W   = $clog2(NUM_LAYERS + 1);
  localparam logic ACT_LVL = (SYNC_POL != 0);
  localparam logic IDLE_LVL = inactive_sync(ACT_LVL);
  localparam logic KEY_ON  = (KEY_EN != 0);

  // Stage-1 pipe registers
  logic [NUM_LAYERS*COLOR_W-1:0] rgb_s1_r;
  logic [NUM_LAYERS-1:0]         valid_s1_r;
  logic                          hsync_s1_r;
  logic                          vsync_s1_r;
  logic                          video_on_s1_r;

  // Frame-shadowed configuration and frame counter
  logic [NUM_LAYERS-1:0]         en_sh_r;
  logic [NUM_LAYERS-1:0]         blink_sh_r;
  logic [COLOR_W-1:0]            bg_sh_r;
  logic [COLOR_W-1:0]            key_sh_r;
  logic [FRAME_W-1:0]            frame_cnt_r;

  // Stage-2 combinational results
  logic [NUM_LAYERS-1:0]         visible_s;
  logic [COLOR_W-1:0]            sel_rgb_s;
  logic [HIT_W-1:0]              sel_idx_s;
  logic                          blink_phase_s;
  logic                          frame_start_s;

  assign blink_phase_s = frame_cnt_r[BLINK_SHIFT];

  // A frame starts on the tick where the registered vsync is about to become active.
  assign frame_start_s = pixel_tick & (vsync_in == ACT_LVL) & (vsync_s1_r == IDLE_LVL);

  // Per-layer visibility: covered, enabled, not blinked off and not the key colour.
  always_comb begin
    visible_s = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      visible_s[i] = valid_s1_r[i] & en_sh_r[i]
                   & ~(blink_sh_r[i] & blink_phase_s)
                   & ~(KEY_ON & (rgb_s1_r[i*COLOR_W +: COLOR_W] == key_sh_r));
    end
  end

  vga_priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W),
    .IDX_W      (HIT_W)
  ) u_select (
    .visible   (visible_s),
    .layer_rgb (rgb_s1_r),
    .bg_rgb    (bg_sh_r),
    .sel_rgb   (sel_rgb_s),
    .sel_idx   (sel_idx_s)
  );

  // Stage 1: capture the incoming pixel and its timing flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_s1_r      <= '0;
      valid_s1_r    <= '0;
      hsync_s1_r    <= IDLE_LVL;
      vsync_s1_r    <= IDLE_LVL;
      video_on_s1_r <= 1'b0;
    end else if (pixel_tick) begin
      rgb_s1_r      <= layer_rgb;
      valid_s1_r    <= layer_valid;
      hsync_s1_r    <= hsync_in;
      vsync_s1_r    <= vsync_in;
      video_on_s1_r <= video_on_in;
    end
  end

  // Stage 2: register the composited colour and the aligned sync outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out      <= COLOR_W'(BLACK);
      hit_layer    <= HIT_W'(NUM_LAYERS);
      hsync_out    <= IDLE_LVL;
      vsync_out    <= IDLE_LVL;
      video_on_out <= 1'b0;
    end else if (pixel_tick) begin
      hsync_out    <= hsync_s1_r;
      vsync_out    <= vsync_s1_r;
      video_on_out <= video_on_s1_r;
      if (video_on_s1_r) begin
        rgb_out   <= sel_rgb_s;
        hit_layer <= sel_idx_s;
      end else begin
        rgb_out   <= COLOR_W'(BLACK);
        hit_layer <= HIT_W'(NUM_LAYERS);
      end
    end
  end

  // Frame counter and configuration shadows update only at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= '0;
      en_sh_r     <= '1;
      blink_sh_r  <= '0;
      bg_sh_r     <= '0;
      key_sh_r    <= '0;
    end else if (frame_start_s) begin
      frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
      en_sh_r     <= layer_en;
      blink_sh_r  <= blink_mask;
      bg_sh_r     <= bg_rgb;
      key_sh_r    <= key_rgb;
    end
  end

  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench: table vectors, directed corner sequences and randomized run against a model.
module tb_vga_layer_compositor;

  localparam int NL = 8;
  localparam int CW = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              pixel_tick;
  logic              hsync_in, vsync_in, video_on_in;
  logic [NL*CW-1:0]  layer_rgb;
  logic [NL-1:0]     layer_valid, layer_en, blink_mask;
  logic [CW-1:0]     bg_rgb, key_rgb;
  logic              hsync_out, vsync_out, video_on_out;
  logic [CW-1:0]     rgb_out;
  logic [3:0]        hit_layer;
  logic [7:0]        frame_cnt;

  int tests = 0;
  int fails = 0;

  vga_layer_compositor dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_on_in(video_on_in),
    .layer_rgb(layer_rgb), .layer_valid(layer_valid), .layer_en(layer_en),
    .blink_mask(blink_mask), .bg_rgb(bg_rgb), .key_rgb(key_rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out),
    .rgb_out(rgb_out), .hit_layer(hit_layer), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: the pixel waiting to be composited, config in force, expected outputs.
  logic [CW-1:0] p_rgb [NL];
  logic [NL-1:0] p_valid;
  logic          p_hs, p_vs, p_von;
  logic [NL-1:0] c_en, c_blink;
  logic [CW-1:0] c_bg, c_key;
  logic [7:0]    m_frame;
  logic [CW-1:0] e_rgb;
  logic [3:0]    e_hit;
  logic          e_hs, e_vs, e_von;

  typedef struct {
    logic [NL-1:0] valid;
    logic [CW-1:0] l1, l2;
    logic          von;
    logic [CW-1:0] exp_rgb;
    logic [3:0]    exp_hit;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // First visible layer by index, or background; returns {index, colour}.
  function automatic logic [15:0] compose();
    for (int i = 0; i < NL; i++) begin
      if (p_valid[i] && c_en[i] && !(c_blink[i] && m_frame[4]) && (p_rgb[i] != c_key))
        return {4'(i), p_rgb[i]};
    end
    return {4'd8, c_bg};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) p_rgb[i] = 12'h000;
    p_valid = 8'h00; p_hs = 1'b1; p_vs = 1'b1; p_von = 1'b0;
    c_en = 8'hFF; c_blink = 8'h00; c_bg = 12'h000; c_key = 12'h000;
    m_frame = 8'd0;
    e_rgb = 12'h000; e_hit = 4'd8; e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] r;
    if (reset) begin
      model_reset();
    end else if (pixel_tick) begin
      r     = compose();
      e_rgb = p_von ? r[11:0] : 12'h000;
      e_hit = p_von ? r[15:12] : 4'd8;
      e_hs  = p_hs; e_vs = p_vs; e_von = p_von;
      if (vsync_in == 1'b0 && p_vs == 1'b1) begin
        m_frame = m_frame + 8'd1;
        c_en = layer_en; c_blink = blink_mask; c_bg = bg_rgb; c_key = key_rgb;
      end
      for (int i = 0; i < NL; i++) p_rgb[i] = layer_rgb[i*CW +: CW];
      p_valid = layer_valid; p_hs = hsync_in; p_vs = vsync_in; p_von = video_on_in;
    end
  endtask

  task automatic check_model();
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    chk("hit_layer", 32'(hit_layer), 32'(e_hit));
    chk("hsync_out", 32'(hsync_out), 32'(e_hs));
    chk("vsync_out", 32'(vsync_out), 32'(e_vs));
    chk("video_on_out", 32'(video_on_out), 32'(e_von));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_pixel(input logic [NL-1:0] v, input logic [CW-1:0] l1, input logic [CW-1:0] l2);
    for (int i = 0; i < NL; i++) layer_rgb[i*CW +: CW] = 12'(12'h111 * (i + 1));
    layer_rgb[1*CW +: CW] = l1;
    layer_rgb[2*CW +: CW] = l2;
    layer_valid = v;
  endtask

  task automatic frame_pulse();
    vsync_in = 1'b0; step();
    vsync_in = 1'b1; step();
  endtask

  logic [7:0]    prev_f;
  logic [CW-1:0] snap_rgb;
  logic [3:0]    snap_hit;
  logic          hs_pat [8];
  logic [CW-1:0] pal [5];

  initial begin
    vecs[0] = '{8'h06, 12'hF00, 12'h0F0, 1'b1, 12'hF00, 4'd1};
    vecs[1] = '{8'h06, 12'hF00, 12'h0F0, 1'b0, 12'h000, 4'd8};
    vecs[2] = '{8'h04, 12'hF00, 12'h0F0, 1'b1, 12'h0F0, 4'd2};
    vecs[3] = '{8'h00, 12'hF00, 12'h0F0, 1'b1, 12'h000, 4'd8};
    vecs[4] = '{8'h02, 12'h000, 12'h0F0, 1'b1, 12'h000, 4'd8};
    vecs[5] = '{8'h06, 12'h000, 12'h0F0, 1'b1, 12'h0F0, 4'd2};
    vecs[6] = '{8'h81, 12'hF00, 12'h0F0, 1'b1, 12'h111, 4'd0};
    vecs[7] = '{8'h80, 12'hF00, 12'h0F0, 1'b1, 12'h888, 4'd7};

    reset = 1'b1; pixel_tick = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; video_on_in = 1'b1;
    layer_en = 8'hFF; blink_mask = 8'h00; bg_rgb = 12'h000; key_rgb = 12'h000;
    set_pixel(8'h00, 12'h000, 12'h000);
    model_reset();

    // Reset held three cycles
    repeat (3) step();
    chk("reset_rgb", 32'(rgb_out), 32'h000);
    chk("reset_hsync", 32'(hsync_out), 32'h1);
    chk("reset_vsync", 32'(vsync_out), 32'h1);
    chk("reset_hit", 32'(hit_layer), 32'd8);
    chk("reset_frame", 32'(frame_cnt), 32'd0);
    reset = 1'b0;

    // Table vectors with reset-default configuration
    for (int v = 0; v < 8; v++) begin
      set_pixel(vecs[v].valid, vecs[v].l1, vecs[v].l2);
      video_on_in = vecs[v].von;
      step(); step();
      chk($sformatf("vec%0d_rgb", v), 32'(rgb_out), 32'(vecs[v].exp_rgb));
      chk($sformatf("vec%0d_hit", v), 32'(hit_layer), 32'(vecs[v].exp_hit));
    end

    // Sync delay line: output follows input two ticks later
    hs_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    video_on_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      hsync_in = hs_pat[k];
      step();
      if (k >= 1) chk("hsync_delay", 32'(hsync_out), 32'(hs_pat[k-1]));
    end
    hsync_in = 1'b1; video_on_in = 1'b1;

    // Shadowing: mid-frame enable change waits for the next frame start
    set_pixel(8'h06, 12'hF00, 12'h0F0);
    frame_pulse();
    layer_en = 8'hFD;
    repeat (4) step();
    chk("shadow_hold_rgb", 32'(rgb_out), 32'hF00);
    chk("shadow_hold_hit", 32'(hit_layer), 32'd1);
    frame_pulse();
    step();
    chk("shadow_new_rgb", 32'(rgb_out), 32'h0F0);
    chk("shadow_new_hit", 32'(hit_layer), 32'd2);

    // Blink across enough frames to cover the counter wrap
    layer_en = 8'hFF; blink_mask = 8'h02; key_rgb = 12'h000;
    for (int f = 0; f < 260; f++) begin
      prev_f = frame_cnt;
      frame_pulse();
      step();
      if (prev_f == 8'hFF) chk("frame_wrap", 32'(frame_cnt), 32'd0);
      chk("blink_rgb", 32'(rgb_out), frame_cnt[4] ? 32'h0F0 : 32'hF00);
    end

    // Key latch then pixel_tick stalled: outputs frozen until ticks resume
    blink_mask = 8'h00;
    frame_pulse();
    step();
    key_rgb = 12'hF00;
    vsync_in = 1'b0; step();
    vsync_in = 1'b1;
    snap_rgb = rgb_out; snap_hit = hit_layer; prev_f = frame_cnt;
    chk("pre_stall_rgb", 32'(snap_rgb), 32'hF00);
    pixel_tick = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_pixel(8'($urandom), 12'($urandom), 12'($urandom));
      step();
      chk("stall_rgb", 32'(rgb_out), 32'(snap_rgb));
      chk("stall_hit", 32'(hit_layer), 32'(snap_hit));
      chk("stall_frame", 32'(frame_cnt), 32'(prev_f));
    end
    set_pixel(8'h06, 12'hF00, 12'h0F0);
    pixel_tick = 1'b1;
    step();
    chk("keyed_rgb", 32'(rgb_out), 32'h0F0);
    chk("keyed_hit", 32'(hit_layer), 32'd2);

    // Randomized run against the model, including mid-run resets
    pal = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'h5A5};
    for (int n = 0; n < 2000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      pixel_tick  = ($urandom_range(0, 3) != 0);
      hsync_in    = ($urandom_range(0, 5) != 0);
      vsync_in    = ($urandom_range(0, 15) != 0);
      video_on_in = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < NL; i++) layer_rgb[i*CW +: CW] = pal[$urandom_range(0, 4)];
      layer_valid = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        layer_en   = 8'($urandom);
        blink_mask = 8'($urandom);
        bg_rgb     = pal[$urandom_range(0, 4)];
        key_rgb    = pal[$urandom_range(0, 4)];
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
